// File: rtl/elastic_buffer_pkg.sv
// elastic_buffer_pkg: shared symbol constants and FSM state type for the RX elastic buffer
package elastic_buffer_pkg;
    localparam logic [9:0] SKIP_SYMBOL  = 10'h1A1;
    localparam logic [9:0] COMMA_SYMBOL = 10'h1BC;
    typedef enum logic {EB_FILL, EB_RUN} eb_state_e;
endpackage

// File: rtl/skp_compensating_fifo_if.sv
// skp_compensating_fifo_if: incoming symbol stream and registered outgoing symbol stream
interface skp_compensating_fifo_if #(parameter int DATA_W = 10);
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    modport master (output in_valid, data_in, out_ready, input data_out, out_valid);
    modport slave  (input in_valid, data_in, out_ready, output data_out, out_valid);
endinterface

// File: rtl/eb_symbol_ram.sv
// eb_symbol_ram: symbol storage with one write port and two async read ports (head, head+1)
module eb_symbol_ram #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
endmodule

// File: rtl/skp_compensating_fifo.sv
// skp_compensating_fifo: rate-compensation FIFO that re-centres fill by inserting/dropping SKIPs
// inside SKIP runs, with sticky overflow/underflow flags and saturating event counters.
module skp_compensating_fifo
    import elastic_buffer_pkg::eb_state_e, elastic_buffer_pkg::EB_FILL, elastic_buffer_pkg::EB_RUN;
#(
    parameter int DATA_W  = 10,
    parameter int DEPTH   = 16,
    parameter int LOW_WM  = 4,
    parameter int HIGH_WM = 12,
    parameter int CNT_W   = 8,
    parameter logic [DATA_W-1:0] SKIP_SYMBOL = DATA_W'(elastic_buffer_pkg::SKIP_SYMBOL)
) (
    input  logic                     local_clock,
    input  logic                     rst_n,
    input  logic                     clear_err,
    skp_compensating_fifo_if.slave   bus,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     skp_added,
    output logic                     skp_dropped,
    output logic                     overflow,
    output logic                     underflow,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [CNT_W-1:0]         udf_count
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] HALF = (ADDR_W+1)'(DEPTH / 2);
    localparam logic [ADDR_W:0] LOW  = (ADDR_W+1)'(LOW_WM);
    localparam logic [ADDR_W:0] HIGH = (ADDR_W+1)'(HIGH_WM);
    localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ADDR_W:0] wr_q, wr_d, rd_q, rd_d, fill;
    eb_state_e state_q, state_d;
    logic [DATA_W-1:0] dout_q, dout_d, head_sym, nxt_sym, emit_sym;
    logic vld_q, vld_d, add_q, drop_q, last_skp_q, last_skp_d;
    logic ins_done_q, ins_done_d, drp_done_q, drp_done_d;
    logic ovf_q, ovf_d, udf_q, udf_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;
    logic push, ovf_ev, udf_ev, run_rdy, do_ins, do_drop, do_pop, emit, run_end;

    eb_symbol_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk      (local_clock),
        .we_i     (push),
        .waddr_i  (wr_q[ADDR_W-1:0]),
        .wdata_i  (bus.data_in),
        .raddr0_i (rd_q[ADDR_W-1:0]),
        .raddr1_i (rd_q[ADDR_W-1:0] + ADDR_W'(1)),
        .rdata0_o (head_sym),
        .rdata1_o (nxt_sym)
    );

    assign fill    = wr_q - rd_q;
    assign push    = bus.in_valid && fill != FULL;
    assign ovf_ev  = bus.in_valid && fill == FULL;
    assign run_rdy = state_q == EB_RUN && bus.out_ready;
    // Insert/drop only while a SKIP run is in progress, once each per run
    assign do_ins  = run_rdy && last_skp_q && fill < LOW && !ins_done_q;
    assign do_drop = run_rdy && !do_ins && head_sym == SKIP_SYMBOL && last_skp_q
                     && fill > HIGH && fill >= TWO && !drp_done_q;
    assign do_pop  = run_rdy && !do_ins && !do_drop && |fill;
    assign udf_ev  = run_rdy && !do_ins && ~|fill;
    assign emit    = do_ins || do_drop || do_pop;
    assign emit_sym = do_ins ? SKIP_SYMBOL : do_drop ? nxt_sym : head_sym;
    assign run_end = emit && emit_sym != SKIP_SYMBOL;

    always_comb begin
        wr_d       = wr_q + (ADDR_W+1)'(push);
        rd_d       = rd_q + (ADDR_W+1)'({do_drop, do_pop});
        state_d    = state_q == EB_FILL ? (fill >= HALF ? EB_RUN : EB_FILL) : (udf_ev ? EB_FILL : EB_RUN);
        dout_d     = emit ? emit_sym : dout_q;
        vld_d      = emit ? 1'b1 : udf_ev ? 1'b0 : vld_q;
        last_skp_d = emit ? emit_sym == SKIP_SYMBOL : last_skp_q;
        ins_done_d = run_end ? 1'b0 : ins_done_q || do_ins;
        drp_done_d = run_end ? 1'b0 : drp_done_q || do_drop;
        ovf_d      = ovf_ev || (ovf_q && !clear_err);
        udf_d      = udf_ev || (udf_q && !clear_err);
        ovf_cnt_d  = clear_err ? CNT_W'(ovf_ev) : ovf_cnt_q + CNT_W'(ovf_ev && ovf_cnt_q != CNT_MAX);
        udf_cnt_d  = clear_err ? CNT_W'(udf_ev) : udf_cnt_q + CNT_W'(udf_ev && udf_cnt_q != CNT_MAX);
    end

    always_ff @(posedge local_clock or negedge rst_n)
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            state_q    <= EB_FILL;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            add_q      <= 1'b0;
            drop_q     <= 1'b0;
            last_skp_q <= 1'b0;
            ins_done_q <= 1'b0;
            drp_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            ovf_cnt_q  <= '0;
            udf_cnt_q  <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            state_q    <= state_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            add_q      <= do_ins;
            drop_q     <= do_drop;
            last_skp_q <= last_skp_d;
            ins_done_q <= ins_done_d;
            drp_done_q <= drp_done_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            ovf_cnt_q  <= ovf_cnt_d;
            udf_cnt_q  <= udf_cnt_d;
        end

    assign bus.data_out  = dout_q;
    assign bus.out_valid = vld_q;
    assign fill_level    = fill;
    assign skp_added     = add_q;
    assign skp_dropped   = drop_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;
    assign ovf_count     = ovf_cnt_q;
    assign udf_count     = udf_cnt_q;
endmodule
